// File: rtl/present_key_scheduler.sv
// Sequential PRESENT key schedule: accepts an 80- or 128-bit master key and streams round keys
// K1..K32 over a valid/ready handshake, applying one schedule update per accepted round key.
module present_key_scheduler #(
   parameter int unsigned KEY_WIDTH = 80,
   parameter int unsigned NUM_RKEYS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [KEY_WIDTH-1:0] key_in,
   input  logic                 key_valid,
   output logic                 key_ready,
   output logic [63:0]          rk_out,
   output logic [5:0]           rk_round,
   output logic                 rk_valid,
   input  logic                 rk_ready,
   output logic                 rk_last,
   output logic                 busy
);

   localparam logic [5:0] LastRound = 6'(NUM_RKEYS);

   // Only the two PRESENT key sizes exist; anything else is a configuration mistake.
   if ((KEY_WIDTH != 80) && (KEY_WIDTH != 128)) begin : gen_bad_width
      $error("present_key_scheduler: KEY_WIDTH must be 80 or 128");
   end

   if (NUM_RKEYS != 32) begin : gen_bad_rkeys
      $error("present_key_scheduler: NUM_RKEYS is fixed at 32 by PRESENT");
   end

   typedef enum logic [0:0] {
      StIdle,
      StEmit
   } state_e;

   state_e               state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [5:0]           round_q, round_d;

   logic [KEY_WIDTH-1:0] key_rot;
   logic [KEY_WIDTH-1:0] key_upd;
   logic                 key_accept;
   logic                 rk_accept;
   logic                 at_last;

   // PRESENT 4-bit S-box.
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      y = 4'h0;
      unique case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         4'hF: y = 4'h2;
      endcase
      return y;
   endfunction

   // Rotate left by 61: the low KEY_WIDTH-61 bits move to the top.
   assign key_rot = {key_q[KEY_WIDTH-62:0], key_q[KEY_WIDTH-1:KEY_WIDTH-61]};

   if (KEY_WIDTH == 80) begin : gen_upd80
      // 80-bit update: one S-box on the top nibble, round counter into bits 19:15.
      always_comb begin
         key_upd         = key_rot;
         key_upd[79:76]  = sbox(key_rot[79:76]);
         key_upd[19:15]  = key_rot[19:15] ^ round_q[4:0];
      end
   end else begin : gen_upd128
      // 128-bit update: S-box on the top two nibbles, round counter into bits 66:62.
      always_comb begin
         key_upd           = key_rot;
         key_upd[127:124]  = sbox(key_rot[127:124]);
         key_upd[123:120]  = sbox(key_rot[123:120]);
         key_upd[66:62]    = key_rot[66:62] ^ round_q[4:0];
      end
   end

   assign key_accept = (state_q == StIdle) && key_valid;
   assign rk_accept  = (state_q == StEmit) && rk_ready;
   assign at_last    = (round_q == LastRound);

   // FSM state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Key and round registers; cleared by reset so rk_out reads zero afterwards.
   always_ff @(posedge clk) begin
      if (!reset) begin
         key_q   <= '0;
         round_q <= '0;
      end else begin
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

   // FSM next-state: load a key in idle, return to idle after the final round key is taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (key_valid) begin
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (rk_ready && at_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: the final handshake leaves key_q untouched instead of updating it.
   always_comb begin
      key_d   = key_q;
      round_d = round_q;
      if (key_accept) begin
         key_d   = key_in;
         round_d = 6'd1;
      end else if (rk_accept) begin
         if (at_last) begin
            round_d = 6'd0;
         end else begin
            key_d   = key_upd;
            round_d = round_q + 6'd1;
         end
      end
   end

   // FSM outputs: handshake flags and round index decoded from the state.
   always_comb begin
      key_ready = 1'b0;
      rk_valid  = 1'b0;
      busy      = 1'b0;
      rk_round  = 6'd0;
      rk_last   = 1'b0;
      unique case (state_q)
         StIdle: begin
            key_ready = 1'b1;
         end
         StEmit: begin
            rk_valid = 1'b1;
            busy     = 1'b1;
            rk_round = round_q;
            rk_last  = at_last;
         end
         default: begin
            key_ready = 1'b0;
         end
      endcase
   end

   assign rk_out = key_q[KEY_WIDTH-1 -: 64];

   // A stalled round key must not change or be withdrawn.
   a_rk_hold: assert property (@(posedge clk) disable iff (!reset)
      (rk_valid && !rk_ready) |=> (rk_valid && $stable(rk_out) && $stable(rk_round)));

   // The round counter never runs past the last round key.
   a_round_range: assert property (@(posedge clk) disable iff (!reset)
      (round_q <= LastRound));

endmodule

// File: tb/tb_present_key_scheduler.sv
// Bench for present_key_scheduler: one 80-bit and one 128-bit instance, a behavioural key
// schedule model feeding per-instance expectation queues, and a negedge monitor that pops and
// compares on every round-key handshake.
module tb_present_key_scheduler;

   localparam logic [63:0] SboxTab = 64'h21748FE3DA09B65C;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          a_reset = 1'b0, b_reset = 1'b0;
   logic [79:0]   a_key_in = '0;
   logic [127:0]  b_key_in = '0;
   logic          a_key_valid = 1'b0, b_key_valid = 1'b0;
   logic          a_rk_ready = 1'b1, b_rk_ready = 1'b1;
   logic          a_key_ready, b_key_ready, a_rk_valid, b_rk_valid;
   logic          a_rk_last, b_rk_last, a_busy, b_busy;
   logic [63:0]   a_rk_out, b_rk_out;
   logic [5:0]    a_rk_round, b_rk_round;

   int errors = 0;
   int checks = 0;

   logic [69:0] exp_a[$];
   logic [69:0] exp_b[$];
   logic [63:0] mdl_rk [32];
   int          hs_cnt [2];
   bit          prev_stall [2];
   bit          prev_last [2];
   logic [69:0] prev_val [2];

   present_key_scheduler #(.KEY_WIDTH(80), .NUM_RKEYS(32)) u_dut80 (
      .clk(clk), .reset(a_reset), .key_in(a_key_in), .key_valid(a_key_valid),
      .key_ready(a_key_ready), .rk_out(a_rk_out), .rk_round(a_rk_round), .rk_valid(a_rk_valid),
      .rk_ready(a_rk_ready), .rk_last(a_rk_last), .busy(a_busy)
   );

   present_key_scheduler #(.KEY_WIDTH(128), .NUM_RKEYS(32)) u_dut128 (
      .clk(clk), .reset(b_reset), .key_in(b_key_in), .key_valid(b_key_valid),
      .key_ready(b_key_ready), .rk_out(b_rk_out), .rk_round(b_rk_round), .rk_valid(b_rk_valid),
      .rk_ready(b_rk_ready), .rk_last(b_rk_last), .busy(b_busy)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] sbx(input logic [3:0] x);
      logic [63:0] t;
      t = SboxTab >> (4 * x);
      return t[3:0];
   endfunction

   function automatic logic [127:0] put_nib(input logic [127:0] k, input int pos);
      logic [127:0] t;
      t = k >> pos;
      return (k & ~(128'hF << pos)) | (128'(sbx(t[3:0])) << pos);
   endfunction

   // Reference schedule: round key r is the top 64 bits before the r-th update.
   task automatic model_keys(input int w, input logic [127:0] key);
      logic [127:0] k, mask, t, rc;
      mask = {128{1'b1}} >> (128 - w);
      k = key & mask;
      for (int r = 1; r <= 32; r++) begin
         t = k >> (w - 64);
         mdl_rk[r-1] = t[63:0];
         k = ((k << 61) | (k >> (w - 61))) & mask;
         k = put_nib(k, w - 4);
         if (w == 128) k = put_nib(k, w - 8);
         rc = 128'(r % 32);
         k = k ^ (rc << ((w == 80) ? 15 : 62));
      end
   endtask

   task automatic expect_stream(input int id, input logic [127:0] key);
      model_keys((id == 0) ? 80 : 128, key);
      for (int i = 0; i < 32; i++) begin
         if (id == 0) exp_a.push_back({6'(i + 1), mdl_rk[i]});
         else         exp_b.push_back({6'(i + 1), mdl_rk[i]});
      end
   endtask

   function automatic int qsize(input int id);
      return (id == 0) ? exp_a.size() : exp_b.size();
   endfunction

   function automatic logic [69:0] qpop(input int id);
      return (id == 0) ? exp_a.pop_front() : exp_b.pop_front();
   endfunction

   task automatic qflush(input int id);
      if (id == 0) exp_a.delete();
      else         exp_b.delete();
   endtask

   function automatic logic ready_of(input int id);
      return (id == 0) ? a_key_ready : b_key_ready;
   endfunction

   task automatic set_kv(input int id, input logic kv, input logic [127:0] key);
      if (id == 0) begin
         a_key_valid = kv;
         a_key_in    = key[79:0];
      end else begin
         b_key_valid = kv;
         b_key_in    = key;
      end
   endtask

   task automatic set_rdy(input int id, input logic rdy);
      if (id == 0) a_rk_ready = rdy;
      else         b_rk_ready = rdy;
   endtask

   // Monitor: scoreboard pop on handshake plus state-flag and stall-stability checks.
   task automatic mon(input int id, input logic rst, input logic v, input logic rdy,
                      input logic kr, input logic lst, input logic bsy,
                      input logic [63:0] rk, input logic [5:0] rnd);
      logic [69:0] e;
      if (!rst) begin
         prev_stall[id] = 1'b0;
         prev_last[id]  = 1'b0;
         return;
      end
      if (prev_last[id]) chk("ready_after_last", {kr, v}, 2'b10);
      if (prev_stall[id]) chk("stall_hold", {v, rnd, rk}, {1'b1, prev_val[id]});
      if (v) chk("emit_flags", {kr, bsy}, 2'b01);
      else   chk("idle_flags", {kr, bsy, lst, rnd}, {3'b100, 6'd0});
      prev_last[id] = 1'b0;
      if (v && rdy) begin
         if (qsize(id) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rk: dut%0d round %0d key %h with empty queue", id, rnd, rk);
         end else begin
            e = qpop(id);
            chk("rk_round", rnd, e[69:64]);
            chk("rk_out", rk, e[63:0]);
            chk("rk_last", lst, e[69:64] == 6'd32);
            prev_last[id] = (e[69:64] == 6'd32);
         end
         hs_cnt[id]++;
      end
      prev_stall[id] = v && !rdy;
      prev_val[id]   = {rnd, rk};
   endtask

   // Sample both instances on the falling edge, away from the active edge.
   always @(negedge clk) begin
      mon(0, a_reset, a_rk_valid, a_rk_ready, a_key_ready, a_rk_last, a_busy, a_rk_out, a_rk_round);
      mon(1, b_reset, b_rk_valid, b_rk_ready, b_key_ready, b_rk_last, b_busy, b_rk_out, b_rk_round);
   end

   task automatic load(input int id, input logic [127:0] key);
      chk("ready_before_load", ready_of(id), 1'b1);
      hs_cnt[id] = 0;
      expect_stream(id, key);
      set_kv(id, 1'b1, key);
      @(posedge clk);
      #1;
      set_kv(id, 1'b0, '0);
   endtask

   task automatic finish_stream(input int id, input bit bp, input int exp_hs);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (ready_of(id)) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (bp) set_rdy(id, ($urandom_range(0, 3) != 0));
      end
      @(posedge clk);
      #1;
      set_rdy(id, 1'b1);
      chk("stream_done", done, 1'b1);
      chk("hs_count", hs_cnt[id], exp_hs);
      chk("queue_empty", qsize(id), 0);
   endtask

   initial begin
      logic [127:0] rk;
      bit found;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_a", {a_key_ready, a_rk_valid, a_rk_last, a_busy, a_rk_round, a_rk_out},
          {4'b1000, 6'd0, 64'h0});
      chk("reset_b", {b_key_ready, b_rk_valid, b_rk_last, b_busy, b_rk_round, b_rk_out},
          {4'b1000, 6'd0, 64'h0});
      @(posedge clk);
      #1;
      a_reset = 1'b1;
      b_reset = 1'b1;

      // 80-bit all-zero key, no backpressure.
      load(0, '0);
      @(negedge clk); chk("k80_K1", {a_rk_round, a_rk_out}, {6'd1, 64'h0});
      @(posedge clk); #1;
      @(negedge clk); chk("k80_K2", {a_rk_round, a_rk_out}, {6'd2, 64'hC000000000000000});
      @(posedge clk); #1;
      @(negedge clk); chk("k80_K3", {a_rk_round, a_rk_out}, {6'd3, 64'h5000180000000001});
      @(posedge clk); #1;
      finish_stream(0, 1'b0, 32);

      // 128-bit all-zero key.
      load(1, '0);
      @(negedge clk); chk("k128_K1", {b_rk_round, b_rk_out}, {6'd1, 64'h0});
      @(posedge clk); #1;
      @(negedge clk); chk("k128_K2", {b_rk_round, b_rk_out}, {6'd2, 64'hCC00000000000000});
      @(posedge clk); #1;
      finish_stream(1, 1'b0, 32);

      // Backpressure at round 2.
      load(0, '0);
      @(posedge clk); #1;
      set_rdy(0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold", {a_rk_valid, a_rk_round, a_rk_out}, {1'b1, 6'd2, 64'hC000000000000000});
         @(posedge clk); #1;
      end
      set_rdy(0, 1'b1);
      @(posedge clk); #1;
      @(negedge clk); chk("bp_K3", {a_rk_round, a_rk_out}, {6'd3, 64'h5000180000000001});
      @(posedge clk); #1;
      finish_stream(0, 1'b1, 32);

      // key_valid with a different key during EMIT is ignored.
      rk = {48'h0, $urandom(), $urandom(), 16'($urandom())};
      load(0, rk);
      repeat (3) begin
         set_kv(0, 1'b1, ~rk);
         @(negedge clk);
         chk("ready_in_emit", a_key_ready, 1'b0);
         @(posedge clk); #1;
      end
      set_kv(0, 1'b0, '0);
      finish_stream(0, 1'b1, 32);

      // Reset in the middle of a stream, at round 17.
      load(0, '0);
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (a_rk_round == 6'd16) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("reach_round16", found, 1'b1);
      @(posedge clk); #1;
      chk("round_at_reset", a_rk_round, 6'd17);
      a_reset = 1'b0;
      qflush(0);
      @(posedge clk); #1;
      a_reset = 1'b1;
      @(negedge clk);
      chk("midreset_flags", {a_rk_valid, a_busy, a_key_ready, a_rk_last, a_rk_round},
          {4'b0010, 6'd0});
      chk("midreset_rk_out", a_rk_out, 64'h0);
      @(posedge clk); #1;
      load(0, '0);
      @(negedge clk); chk("restart_K1", {a_rk_round, a_rk_out}, {6'd1, 64'h0});
      @(posedge clk); #1;
      finish_stream(0, 1'b0, 32);

      // Back-to-back keys with key_valid held high throughout.
      hs_cnt[0] = 0;
      expect_stream(0, '0);
      expect_stream(0, 128'({80{1'b1}}));
      set_kv(0, 1'b1, '0);
      @(posedge clk); #1;
      set_kv(0, 1'b1, 128'({80{1'b1}}));
      repeat (32) @(posedge clk);
      @(negedge clk);
      chk("b2b_gap", {a_key_ready, a_rk_valid}, 2'b10);
      @(posedge clk); #1;
      set_kv(0, 1'b0, '0);
      @(negedge clk);
      chk("b2b_K1", {a_rk_valid, a_rk_round, a_rk_out}, {1'b1, 6'd1, 64'hFFFFFFFFFFFFFFFF});
      @(posedge clk); #1;
      finish_stream(0, 1'b0, 64);

      // Random keys with random backpressure on both widths.
      for (int it = 0; it < 4; it++) begin
         load(0, {48'h0, $urandom(), $urandom(), 16'($urandom())});
         finish_stream(0, 1'b1, 32);
         load(1, {$urandom(), $urandom(), $urandom(), $urandom()});
         finish_stream(1, 1'b1, 32);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/present_key_scheduler.md
# present_key_scheduler

Sequential PRESENT key-schedule engine, parametrised for 80- and 128-bit master keys. It accepts a master key over a valid/ready handshake. It then streams the 32 round keys K1..K32 (64 bits each) over a second valid/ready handshake, one update per accepted round key. It sits between key storage and the cipher datapath and replaces the combinational one-round KSA in sequenced designs.

## Interface
- KEY_WIDTH, default 80: master key width; legal values are 80 and 128 only; any other value is an elaboration error.
- NUM_RKEYS, default 32: round keys emitted per master key; fixed by PRESENT.
- Reset: reset, synchronous, active-low; clock: clk.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous active-low reset.
- key_in  in  KEY_WIDTH  master key, MSB = k[KEY_WIDTH-1].
- key_valid  in  1  key_in valid.
- key_ready  out  1  block can accept a master key.
- rk_out  out  64  current round key = key_reg[KEY_WIDTH-1 -: 64].
- rk_round  out  6  index of rk_out, 1..32; 0 when idle.
- rk_valid  out  1  rk_out/rk_round valid.
- rk_ready  in  1  consumer accepts round key.
- rk_last  out  1  high with rk_valid when rk_round == 32.
- busy  out  1  high in EMIT state.

## Operation
- FSM states are IDLE and EMIT.
- IDLE:
  - key_ready=1, rk_valid=0, busy=0, rk_round=0.
  - key_valid&&key_ready loads key_in into key_reg, sets round=1, and moves to EMIT.
- EMIT:
  - key_ready=0, rk_valid=1, busy=1.
  - On rk_valid&&rk_ready with round<32: apply one update to key_reg, round<=round+1.
  - On rk_valid&&rk_ready with round==32: go to IDLE; key_reg holds its value.
- Update for KEY_WIDTH=80, in order:
  - rotate left 61;
  - k[79:76]=S(k[79:76]);
  - k[19:15] ^= round[4:0], where round is the index of the key just consumed (1..31).
- Update for KEY_WIDTH=128, in order:
  - rotate left 61;
  - k[127:124]=S(k[127:124]);
  - k[123:120]=S(k[123:120]);
  - k[66:62] ^= round[4:0].
- S-box, 0..F maps to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- rk_out is a pure slice of key_reg, with no extra register.
- key_valid in EMIT is ignored; key_in is not sampled there.
- rk_ready low in EMIT:
  - key_reg and round are held;
  - rk_out and rk_round stay stable;
  - rk_valid stays high and never drops before a handshake.
- rk_ready in IDLE is ignored.

## Timing
- Reset (reset==0 at a rising edge) forces the following, regardless of state, including mid-stream:
  - state=IDLE;
  - key_reg=0, round=0;
  - outputs: key_ready=1, rk_valid=0, rk_last=0, busy=0, rk_out=0, rk_round=0.
- An in-flight stream is discarded with no further rk_valid.
- key_ready=1 holds from the first edge with reset==0 while in IDLE.
- Key-load handshake at edge N: rk_valid=1 with rk_round=1 and rk_out=K1 in the cycle after edge N.
- Throughput with rk_ready tied high: one round key per cycle; K1..K32 occupy 32 consecutive cycles.
- Final handshake at edge M: key_ready=1 in the cycle after M. The next master key can be accepted at edge M+1, giving a one-cycle bubble between streams.
- The round counter is 6 bits and never wraps past 32; the EMIT→IDLE transition replaces the increment at 32.

## Test plan
- KEY_WIDTH=80, key 0, rk_ready=1:
  - K1=0000000000000000, K2=C000000000000000, K3=5000180000000001;
  - rk_last only on rk_round=32;
  - key_ready high the cycle after.
- KEY_WIDTH=128, key 0: K1=0000000000000000, K2=CC00000000000000; exactly 32 rk_valid handshakes.
- Backpressure: rk_ready low for 5 cycles while rk_round=2. rk_out stays C000000000000000, rk_round stays 2 and rk_valid stays 1. After release, K3=5000180000000001 follows.
- key_valid pulsed with a different key_in during EMIT: no effect. The stream completes with the original key's round keys and key_ready stays 0 until the stream ends.
- Reset (reset=0) asserted at rk_round=17:
  - next cycle: rk_valid=0, busy=0, rk_out=0, key_ready=1;
  - a new key-0 load restarts cleanly at K1.
- Back-to-back keys 0 then FFFFFFFFFFFFFFFFFFFF (80-bit):
  - the second key is accepted exactly one cycle after the first stream's final handshake;
  - its K1=FFFFFFFFFFFFFFFF.
